// File: rtl/ssd_scan_ctrl_if.sv
// Bus bundle between the display scan controller and its driver: control/data in, display lines out.
interface ssd_scan_ctrl_if;
   logic        i_en;
   logic        i_load;
   logic [15:0] i_disp_in;
   logic [3:0]  o_bcd_out;
   logic [3:0]  o_ssd_ctl;
   logic        o_frame_done;

   modport master (
      output i_en, i_load, i_disp_in,
      input  o_bcd_out, o_ssd_ctl, o_frame_done
   );

   modport slave (
      input  i_en, i_load, i_disp_in,
      output o_bcd_out, o_ssd_ctl, o_frame_done
   );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller with an inter-digit guard gap and a
// double-buffered display value. Define SSD_LZ_BLANK_EN to enable leading-zero blanking.
module ssd_scan_ctrl #(
   parameter int REFRESH_CNT = 100000,
   parameter int GUARD_CYC   = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   ssd_scan_ctrl_if.slave bus
);
   localparam int CNT_HI  = (REFRESH_CNT > GUARD_CYC) ? REFRESH_CNT : GUARD_CYC;
   localparam int CNT_MAX = (CNT_HI > 2) ? CNT_HI : 2;
   localparam int CW      = $clog2(CNT_MAX);
   localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_CNT - 1);
   localparam logic [CW-1:0] GRD_LAST = CW'((GUARD_CYC > 0) ? (GUARD_CYC - 1) : 0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_SHOW  = 2'd1,
      ST_GUARD = 2'd2
   } state_t;

   state_t        r_state;
   logic [1:0]    r_idx;
   logic [CW-1:0] r_cnt;
   logic [15:0]   r_shadow;
   logic [15:0]   r_active;
   logic [3:0]    r_bcd;
   logic [3:0]    r_ctl;
   logic          r_fd;

   state_t        w_state_nx;
   logic [1:0]    w_idx_nx;
   logic [CW-1:0] w_cnt_nx;
   logic [15:0]   w_active_nx;
   logic [3:0]    w_bcd_nx;
   logic [3:0]    w_ctl_nx;
   logic          w_fd_nx;

   function automatic logic [3:0] digit_code(input logic [15:0] val, input logic [1:0] k);
      logic [3:0] nib;
      nib = val[{k, 2'b00} +: 4];
`ifdef SSD_LZ_BLANK_EN
      // A digit is blank when it and every more significant digit are zero.
      if ((k != 2'd0) && ((val >> {k, 2'b00}) == 16'd0)) begin
         nib = 4'd15;
      end else begin
         nib = val[{k, 2'b00} +: 4];
      end
`endif
      return nib;
   endfunction

   // Next-state logic; output values are derived from the next state so they can be registered.
   always_comb begin
      w_state_nx  = r_state;
      w_idx_nx    = r_idx;
      w_cnt_nx    = r_cnt;
      w_active_nx = r_active;
      case (r_state)
         ST_OFF: begin
            w_idx_nx = 2'd0;
            w_cnt_nx = '0;
            if (bus.i_en) begin
               w_state_nx  = ST_SHOW;
               w_active_nx = r_shadow;
            end else begin
               w_state_nx = ST_OFF;
            end
         end
         ST_SHOW: begin
            if (!bus.i_en) begin
               w_state_nx = ST_OFF;
               w_idx_nx   = 2'd0;
               w_cnt_nx   = '0;
            end else if (r_cnt == REF_LAST) begin
               w_cnt_nx   = '0;
               w_idx_nx   = r_idx + 2'd1;
               w_state_nx = (GUARD_CYC == 0) ? ST_SHOW : ST_GUARD;
               if (r_idx == 2'd3) begin
                  w_active_nx = r_shadow;
               end else begin
                  w_active_nx = r_active;
               end
            end else begin
               w_cnt_nx = r_cnt + CNT_ONE;
            end
         end
         ST_GUARD: begin
            if (!bus.i_en) begin
               w_state_nx = ST_OFF;
               w_idx_nx   = 2'd0;
               w_cnt_nx   = '0;
            end else if (r_cnt == GRD_LAST) begin
               w_state_nx = ST_SHOW;
               w_cnt_nx   = '0;
            end else begin
               w_cnt_nx = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_state_nx = ST_OFF;
            w_idx_nx   = 2'd0;
            w_cnt_nx   = '0;
         end
      endcase

      w_ctl_nx = 4'b1111;
      w_bcd_nx = 4'd15;
      if (w_state_nx == ST_SHOW) begin
         w_ctl_nx = ~(4'b0001 << w_idx_nx);
         w_bcd_nx = digit_code(w_active_nx, w_idx_nx);
      end else if (w_state_nx == ST_GUARD) begin
         w_bcd_nx = digit_code(w_active_nx, w_idx_nx);
      end else begin
         w_bcd_nx = 4'd15;
      end
      w_fd_nx = (w_state_nx == ST_SHOW) && (w_idx_nx == 2'd3) && (w_cnt_nx == REF_LAST);
   end

   // State, buffers and registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_OFF;
         r_idx    <= 2'd0;
         r_cnt    <= '0;
         r_shadow <= 16'hFFFF;
         r_active <= 16'hFFFF;
         r_bcd    <= 4'd15;
         r_ctl    <= 4'b1111;
         r_fd     <= 1'b0;
      end else begin
         if (bus.i_load) begin
            r_shadow <= bus.i_disp_in;
         end else begin
            r_shadow <= r_shadow;
         end
         r_state  <= w_state_nx;
         r_idx    <= w_idx_nx;
         r_cnt    <= w_cnt_nx;
         r_active <= w_active_nx;
         r_bcd    <= w_bcd_nx;
         r_ctl    <= w_ctl_nx;
         r_fd     <= w_fd_nx;
      end
   end

   assign bus.o_bcd_out    = r_bcd;
   assign bus.o_ssd_ctl    = r_ctl;
   assign bus.o_frame_done = r_fd;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: two instances (R=4/G=1 and R=2/G=0) driven by the same inputs and
// compared every cycle against a slot/frame arithmetic model of the scan timing.
module tb_ssd_scan_ctrl;
   localparam int R0 = 4;
   localparam int G0 = 1;
   localparam int R1 = 2;
   localparam int G1 = 0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ssd_scan_ctrl_if bus0 ();
   ssd_scan_ctrl_if bus1 ();

   ssd_scan_ctrl #(.REFRESH_CNT(R0), .GUARD_CYC(G0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   ssd_scan_ctrl #(.REFRESH_CNT(R1), .GUARD_CYC(G1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   int checks = 0;
   int errors = 0;

   logic        d_en;
   logic        d_ld;
   logic [15:0] d_din;

   int          rr [2] = '{R0, R1};
   int          gg [2] = '{G0, G1};
   bit          m_on   [2];
   int          m_t    [2];
   int          m_fidx [2];
   logic [15:0] m_fval [2];
   logic [15:0] m_shadow;

   task automatic drive(input logic en, input logic ld, input logic [15:0] din);
      d_en = en; d_ld = ld; d_din = din;
      bus0.i_en = en; bus0.i_load = ld; bus0.i_disp_in = din;
      bus1.i_en = en; bus1.i_load = ld; bus1.i_disp_in = din;
   endtask

   function automatic int frame_of(int t, int r, int g);
      int p, s;
      p = r + g;
      s = t / p;
      return ((t % p) < r) ? (s / 4) : ((s + 1) / 4);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) m_on[i] = 1'b0;
      m_shadow = 16'hFFFF;
   endtask

   task automatic model_edge(input int i);
      int fi;
      if (!d_en) begin
         m_on[i] = 1'b0;
      end else if (!m_on[i]) begin
         m_on[i] = 1'b1; m_t[i] = 0; m_fidx[i] = 0; m_fval[i] = m_shadow;
      end else begin
         m_t[i] = m_t[i] + 1;
         fi = frame_of(m_t[i], rr[i], gg[i]);
         if (fi != m_fidx[i]) begin
            m_fidx[i] = fi; m_fval[i] = m_shadow;
         end
      end
   endtask

   task automatic expected(input int i, output logic [3:0] ctl, output logic [3:0] bcd, output logic fd);
      int p, s, pos, k;
      ctl = 4'b1111; bcd = 4'd15; fd = 1'b0;
      if (m_on[i]) begin
         p = rr[i] + gg[i]; s = m_t[i] / p; pos = m_t[i] % p;
         k = (pos < rr[i]) ? (s % 4) : ((s + 1) % 4);
         if (pos < rr[i]) ctl = ~(4'b0001 << k);
         bcd = 4'((m_fval[i] >> (4 * k)) & 16'h000F);
`ifdef SSD_LZ_BLANK_EN
         if (k > 0 && (m_fval[i] >> (4 * k)) == 16'd0) bcd = 4'd15;
`endif
         fd = (pos == rr[i] - 1) && (s % 4 == 3);
      end
   endtask

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [3:0] ec, eb;
      logic       ef;
      expected(0, ec, eb, ef);
      check("dut0_ssd_ctl", bus0.o_ssd_ctl, ec);
      check("dut0_bcd_out", bus0.o_bcd_out, eb);
      check("dut0_frame_done", {3'b000, bus0.o_frame_done}, {3'b000, ef});
      expected(1, ec, eb, ef);
      check("dut1_ssd_ctl", bus1.o_ssd_ctl, ec);
      check("dut1_bcd_out", bus1.o_bcd_out, eb);
      check("dut1_frame_done", {3'b000, bus1.o_frame_done}, {3'b000, ef});
   endtask

   task automatic tick();
      for (int i = 0; i < 2; i++) model_edge(i);
      if (d_ld) m_shadow = d_din;
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) tick();
   endtask

   task automatic run_to_phase(input int phase);
      for (int c = 0; c < 40; c++) begin
         if ((m_t[0] % (4 * (R0 + G0))) == phase) break;
         tick();
      end
   endtask

   initial begin
      drive(1'b0, 1'b0, 16'h0000);
      model_reset();
      #12;
      check_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run(3);

      // Basic frame of 1234 on both instances.
      drive(1'b0, 1'b1, 16'h1234);
      tick();
      drive(1'b1, 1'b0, 16'h0000);
      run(22);

      // Load during digit1: current frame stays on the old value.
      run_to_phase(6);
      drive(1'b1, 1'b1, 16'h5678);
      tick();
      drive(1'b1, 1'b0, 16'h0000);
      run(45);

      // Disable during digit2, then restart.
      run_to_phase(11);
      drive(1'b0, 1'b0, 16'h0000);
      run(3);
      drive(1'b1, 1'b0, 16'h0000);
      run(10);

      // Asynchronous reset mid-digit: outputs dark in the same cycle.
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      drive(1'b0, 1'b0, 16'h0000);
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
      run(4);

      // Leading-zero patterns.
      drive(1'b0, 1'b1, 16'h0050);
      tick();
      drive(1'b1, 1'b0, 16'h0000);
      run(25);
      drive(1'b1, 1'b1, 16'h0000);
      tick();
      drive(1'b1, 1'b0, 16'h0000);
      run(45);

      // Randomised enable/load traffic, including non-BCD and sparse nibbles.
      for (int c = 0; c < 500; c++) begin
         logic [15:0] v;
         v = 16'($urandom);
         if ($urandom_range(0, 1) == 0) v = v & 16'($urandom_range(0, 3) == 0 ? 16'h000F : 16'h00FF);
         drive(($urandom_range(0, 99) < 96) ? 1'b1 : 1'b0,
               ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, v);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
